scrolling_background_layer: RTL and testbench
=============================================

Name: scrolling_background_layer

Overview:
- Parametrised successor to the static ground-line background layer for the dino renderer.
- Draws the ground line plus a dashed ground-texture row scrolling left at a programmable speed; optional parallax cloud layer scrolls at half speed.
- Sits beside the sprite/obstacle layers, driven by the shared hpos/vpos beam counters.
- Output is a 1-bit background colour feeding the layer compositor.

Parameters:
- HPOS_W, 9, width of i_hpos; scroll offsets wrap modulo 2^HPOS_W.
- VPOS_W, 9, width of i_vpos.
- LINE_VPOS, 180, row of the solid ground line.
- DASH_ROW_OFS, 3, texture row = LINE_VPOS + DASH_ROW_OFS.
- DASH_PERIOD_LOG2, 4, dash period = 2^DASH_PERIOD_LOG2 pixels.
- DASH_LEN, 6, lit pixels per period; legal range 1 to period-1.
- SPEED_W, 4, width of i_speed.
- CLOUD_VPOS, 40, top row of the cloud band (clouds build only).
- CLOUD_PERIOD_LOG2, 7, horizontal repeat of clouds = 128 pixels.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- i_hpos  in  HPOS_W  beam x
- i_vpos  in  VPOS_W  beam y
- i_frame_tick  in  1  one-cycle pulse, once per frame in vblank
- i_scroll_en  in  1  1 = advance offsets on frame tick
- i_speed  in  SPEED_W  pixels per frame for the ground layer
- i_restart  in  1  one-cycle pulse: zero all scroll offsets
- o_color_background  out  1  registered background pixel
- o_ground_offset  out  HPOS_W  current ground scroll offset, for obstacle-layer sync

Behaviour:
Reset:
- rst high at a clock edge: o_color_background=0, ground_off=0, cloud_off=0, half-rate toggle=0.

Ground offset update (frame-boundary only):
- On i_frame_tick && i_scroll_en: ground_off <= (ground_off + i_speed) mod 2^HPOS_W.
- Natural wrap; no saturation.
- Offsets never change mid-frame, so there is no tearing.

Restart and priority:
- i_restart: offsets and toggle <= 0, regardless of tick or enable.
- Priority: rst > i_restart > tick update.
- Restart and tick in the same cycle: result is 0, not the speed value.

Other cases:
- i_speed = 0 with enable high: offset holds; cloud toggle still advances.

Pixel function (combinational from registered offsets, then registered):
- gx = (i_hpos + ground_off) mod 2^HPOS_W.
- Pixel on if i_vpos == LINE_VPOS.
- Pixel on if i_vpos == LINE_VPOS+DASH_ROW_OFS and gx[DASH_PERIOD_LOG2-1:0] < DASH_LEN.
- Otherwise 0, unless the cloud term applies.

Timing:
- Latency: exactly 1 clk from hpos/vpos to o_color_background.
- o_ground_offset is a direct register output.
- Coordinates beyond the visible area are not special-cased; the function applies uniformly.

Optional Feature:
- Macro: DINO_BG_CLOUDS_EN.
- Defined:
  - cloud_off advances by 1 on every second qualifying tick (tick && i_scroll_en), using a 1-bit toggle.
  - cx = (i_hpos + cloud_off) mod 2^CLOUD_PERIOD_LOG2.
  - For CLOUD_VPOS ≤ i_vpos < CLOUD_VPOS+8 and cx < 16: pixel ORs in CLOUD_BITMAP[i_vpos-CLOUD_VPOS][cx], a 16x8 constant from the package.
  - Same 1-cycle latency.
- Undefined:
  - No cloud registers or logic.
  - Cloud band outputs 0.

Decomposition:
- Package dino_render_pkg holds:
  - HPOS_W/VPOS_W defaults
  - default LINE_VPOS
  - CLOUD_BITMAP constant (8 rows x 16 bits)
  - a shared bg pixel-function helper, if desired
- Sub-module scroll_offset_counter:
  - Parameters: width; step-divide flag.
  - Inputs: clk, rst, tick, enable, restart, step.
  - Output: offset.
  - Instantiated once for ground; a second time for clouds (step=1, divide-by-2) under DINO_BG_CLOUDS_EN.

Test Plan:
- Reset: hold rst 2 cycles, hpos=0, vpos=180 → o_color_background=0 during reset, 1 one cycle after release; o_ground_offset=0.
- Static dashes: speed=0, vpos=183, sweep hpos 0..31 → output 1 for hpos 0–5 and 16–21, 0 elsewhere; any other vpos except 180 → 0.
- Scroll and wrap: speed=5, enable=1, 103 frame ticks → offset (5·103) mod 512 = 3; at vpos=183, hpos=0 → output 1 (gx=3 < 6); hpos=3 → 0 (gx=6).
- Hold and restart: enable=0 with 10 ticks → offset unchanged; restart coincident with tick at speed=7 → offset=0 next cycle.
- Latency: pulse vpos from 179 to 180 for one cycle → output high exactly one cycle later, for one cycle.
- Clouds (macro defined): 4 qualifying ticks → cloud_off=2; at vpos=CLOUD_VPOS, hpos=0 → output equals CLOUD_BITMAP[0][2]; macro undefined → 0.

Source files
------------

// File: rtl/dino_render_pkg.sv
// rtl/dino_render_pkg.sv - shared constants and cloud bitmap for the dino background layers
package dino_render_pkg;

  localparam int HPOS_W_DEF    = 9;
  localparam int VPOS_W_DEF    = 9;
  localparam int LINE_VPOS_DEF = 180;

  // Cloud sprite, 8 rows x 16 columns; bit index = column within the cloud
  localparam logic [15:0] CLOUD_BITMAP [0:7] = '{
    16'h07E4,
    16'h1FF8,
    16'h3FFC,
    16'h7FFE,
    16'hFFFF,
    16'h7FFE,
    16'h1C38,
    16'h0000
  };

endpackage

// File: rtl/scroll_offset_counter.sv
// rtl/scroll_offset_counter.sv - frame-tick driven scroll offset with optional half-rate stepping
module scroll_offset_counter #(
  parameter int   W      = 9,
  parameter int   STEP_W = 4,
  parameter bit   DIV2   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              enable,
  input  logic              restart,
  input  logic [STEP_W-1:0] step,
  output logic [W-1:0]      offset
);

  logic         toggle;
  logic [W-1:0] step_ext;

  assign step_ext = W'(step);

  // Offset only moves on a qualifying frame tick; restart zeroes it and wins over the tick
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      offset <= '0;
      toggle <= 1'b0;
    end else if (tick && enable) begin
      toggle <= DIV2 ? ~toggle : 1'b0;
      if (!DIV2 || toggle) begin
        offset <= offset + step_ext;
      end
    end
  end

endmodule

// File: rtl/scrolling_background_layer.sv
// rtl/scrolling_background_layer.sv - ground line, scrolling dash row and optional clouds (DINO_BG_CLOUDS_EN)
module scrolling_background_layer
  import dino_render_pkg::*;
#(
  parameter int HPOS_W            = HPOS_W_DEF,
  parameter int VPOS_W            = VPOS_W_DEF,
  parameter int LINE_VPOS         = LINE_VPOS_DEF,
  parameter int DASH_ROW_OFS      = 3,
  parameter int DASH_PERIOD_LOG2  = 4,
  parameter int DASH_LEN          = 6,
  parameter int SPEED_W           = 4,
  parameter int CLOUD_VPOS        = 40,
  parameter int CLOUD_PERIOD_LOG2 = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HPOS_W-1:0] i_hpos,
  input  logic [VPOS_W-1:0] i_vpos,
  input  logic              i_frame_tick,
  input  logic              i_scroll_en,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic              i_restart,
  output logic              o_color_background,
  output logic [HPOS_W-1:0] o_ground_offset
);

  logic [HPOS_W-1:0] ground_off;
  logic [HPOS_W-1:0] gx;
  logic              line_pix;
  logic              dash_pix;
  logic              cloud_pix;
  logic              unused_gx;

  scroll_offset_counter #(
    .W      (HPOS_W),
    .STEP_W (SPEED_W),
    .DIV2   (1'b0)
  ) u_ground_off (
    .clk     (clk),
    .rst     (rst),
    .tick    (i_frame_tick),
    .enable  (i_scroll_en),
    .restart (i_restart),
    .step    (i_speed),
    .offset  (ground_off)
  );

  assign o_ground_offset = ground_off;

  assign gx        = i_hpos + ground_off;
  assign unused_gx = ^gx[HPOS_W-1:DASH_PERIOD_LOG2];
  assign line_pix  = (i_vpos == VPOS_W'(LINE_VPOS));
  assign dash_pix  = (i_vpos == VPOS_W'(LINE_VPOS + DASH_ROW_OFS)) &&
                     (gx[DASH_PERIOD_LOG2-1:0] < DASH_PERIOD_LOG2'(DASH_LEN));

`ifdef DINO_BG_CLOUDS_EN
  logic [CLOUD_PERIOD_LOG2-1:0] cloud_off;
  logic [CLOUD_PERIOD_LOG2-1:0] cx;
  logic [VPOS_W-1:0]            vrel;
  logic                         unused_vrel;

  scroll_offset_counter #(
    .W      (CLOUD_PERIOD_LOG2),
    .STEP_W (1),
    .DIV2   (1'b1)
  ) u_cloud_off (
    .clk     (clk),
    .rst     (rst),
    .tick    (i_frame_tick),
    .enable  (i_scroll_en),
    .restart (i_restart),
    .step    (1'b1),
    .offset  (cloud_off)
  );

  assign cx          = i_hpos[CLOUD_PERIOD_LOG2-1:0] + cloud_off;
  assign vrel        = i_vpos - VPOS_W'(CLOUD_VPOS);
  assign unused_vrel = ^vrel[VPOS_W-1:3];
  assign cloud_pix   = (i_vpos >= VPOS_W'(CLOUD_VPOS)) &&
                       (i_vpos <  VPOS_W'(CLOUD_VPOS + 8)) &&
                       (cx < CLOUD_PERIOD_LOG2'(16)) &&
                       CLOUD_BITMAP[vrel[2:0]][cx[3:0]];
`else
  assign cloud_pix = 1'b0;
`endif

  // Register the composed pixel so the output lags the beam by exactly one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      o_color_background <= 1'b0;
    end else begin
      o_color_background <= line_pix | dash_pix | cloud_pix;
    end
  end

endmodule

// File: tb/tb_scrolling_background_layer.sv
// tb/tb_scrolling_background_layer.sv - randomized self-checking bench with behavioural reference model
module tb_scrolling_background_layer;
  import dino_render_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       frame_tick;
  logic       scroll_en;
  logic [3:0] speed;
  logic       restart;
  logic       color;
  logic [8:0] ground_offset;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state: ground offset as an integer, clouds as a count of qualifying ticks
  int m_ground = 0;
  int m_qticks = 0;

  scrolling_background_layer dut (
    .clk                (clk),
    .rst                (rst),
    .i_hpos             (hpos),
    .i_vpos             (vpos),
    .i_frame_tick       (frame_tick),
    .i_scroll_en        (scroll_en),
    .i_speed            (speed),
    .i_restart          (restart),
    .o_color_background (color),
    .o_ground_offset    (ground_offset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_pix(input int h, input int v, input int goff, input int qt);
    int gx;
    int px;
    gx = (h + goff) % 512;
    px = 0;
    if (v == 180) px = 1;
    if (v == 183 && (gx % 16) < 6) px = 1;
`ifdef DINO_BG_CLOUDS_EN
    begin
      int cx;
      logic [15:0] row;
      cx = (h + (qt / 2)) % 128;
      if (v >= 40 && v < 48 && cx < 16) begin
        row = CLOUD_BITMAP[v - 40];
        if (row[cx]) px = 1;
      end
    end
`endif
    return px;
  endfunction

  task automatic drive(input int h, input int v, input bit tk, input bit en,
                       input int spd, input bit rs, input string tag);
    int exp_pix;
    @(negedge clk);
    hpos = 9'(h); vpos = 9'(v); frame_tick = tk; scroll_en = en;
    speed = 4'(spd); restart = rs;
    @(posedge clk);
    exp_pix = model_pix(h, v, m_ground, m_qticks);
    if (rs) begin
      m_ground = 0;
      m_qticks = 0;
    end else if (tk && en) begin
      m_ground = (m_ground + spd) % 512;
      m_qticks = m_qticks + 1;
    end
    #1;
    check({tag, "_pix"}, int'(color), exp_pix);
    check({tag, "_off"}, int'(ground_offset), m_ground);
  endtask

  initial begin
    rst = 1'b1; hpos = '0; vpos = 9'd180; frame_tick = 1'b0;
    scroll_en = 1'b0; speed = '0; restart = 1'b0;

    // reset held two cycles
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset_pix", int'(color), 0);
      check("reset_off", int'(ground_offset), 0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_pix", int'(color), 1);

    // static dashes at offset zero
    for (int h = 0; h < 32; h++) begin
      drive(h, 183, 0, 0, 0, 0, "static");
      check("static_rule", int'(color), ((h % 16) < 6) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      int v;
      v = 100 + 17 * i;
      if (v == 180 || v == 183) v = 200;
      drive(int'($urandom_range(0, 511)), v, 0, 0, 0, 0, "off_rows");
      check("off_rows_rule", int'(color), 0);
    end

    // scroll and wrap: 103 ticks at speed 5
    for (int i = 0; i < 103; i++) drive(0, 0, 1, 1, 5, 0, "scroll");
    check("scroll_wrap_off", int'(ground_offset), 3);
    drive(0, 183, 0, 1, 5, 0, "scroll_h0");
    check("scroll_h0_rule", int'(color), 1);
    drive(3, 183, 0, 1, 5, 0, "scroll_h3");
    check("scroll_h3_rule", int'(color), 0);

    // hold with enable low
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 9, 0, "hold");
    check("hold_off", int'(ground_offset), 3);

    // restart coincident with tick
    drive(0, 0, 1, 1, 7, 1, "restart");
    check("restart_off", int'(ground_offset), 0);

    // one-cycle latency
    drive(10, 179, 0, 0, 0, 0, "lat_a");
    check("lat_a_rule", int'(color), 0);
    drive(10, 180, 0, 0, 0, 0, "lat_b");
    check("lat_b_rule", int'(color), 1);
    drive(10, 179, 0, 0, 0, 0, "lat_c");
    check("lat_c_rule", int'(color), 0);

    // clouds: four qualifying ticks at speed 0
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0, 0, "cloud_tick");
    check("cloud_ground_hold", int'(ground_offset), 0);
    drive(0, 40, 0, 0, 0, 0, "cloud");
`ifdef DINO_BG_CLOUDS_EN
    begin
      logic [15:0] r0;
      r0 = CLOUD_BITMAP[0];
      check("cloud_rule", int'(color), int'(r0[2]));
    end
`else
    check("cloud_rule", int'(color), 0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int v;
      int sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: v = 180;
        1: v = 183;
        2: v = int'($urandom_range(38, 49));
        default: v = int'($urandom_range(0, 511));
      endcase
      drive(int'($urandom_range(0, 511)), v, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) != 0), int'($urandom_range(0, 15)),
            ($urandom_range(0, 40) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
